alu_exec_ctrl: RTL and testbench

//  Upstream issue/writeback stage for the 4-bit combinational ALU. Accepts one command at a time over valid/ready.

---
 rtl/alu_exec_ctrl.sv | 98 +++++++++
 tb/tb_alu_exec_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_ctrl.sv
// Purpose: issue/writeback stage for the 4-bit ALU; register-file operands in, result and zero flag out.
// Latency: accept edge T -> ALU inputs at T, writeback and res_valid at T+1; one op per 3 cycles at best.
// Backpressure: cmd_ready only in IDLE; RESP holds res_data/res_zero until res_ready, blocking new commands.
module alu_exec_ctrl #(
    parameter int DATA_W   = 4,
    parameter int NUM_REGS = 4,
    parameter int ADDR_W   = 2,
    parameter int CNT_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [ADDR_W-1:0] cmd_src_a,
    input  logic [ADDR_W-1:0] cmd_src_b,
    input  logic              cmd_imm_en,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_f,
    input  logic [DATA_W-1:0] alu_y,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_zero,
    output logic              busy,
    output logic [CNT_W-1:0]  op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [ADDR_W-1:0] dst_q;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // R0 is forced to zero on read so a load is simply ADD R0 + imm.
    always_comb begin
        rd_a = '0;
        rd_b = '0;
        if (cmd_src_a != '0) rd_a = regs[cmd_src_a];
        if (cmd_src_b != '0) rd_b = regs[cmd_src_b];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_f     <= '0;
            dst_q     <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_zero  <= 1'b1;
            op_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        alu_a <= rd_a;
                        alu_b <= cmd_imm_en ? cmd_imm : rd_b;
                        alu_f <= cmd_op;
                        dst_q <= cmd_dst;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    // Writeback lands before RESP, so the next command never sees a stale register.
                    res_data  <= alu_y;
                    res_zero  <= (alu_y == '0);
                    if (dst_q != '0) regs[dst_q] <= alu_y;
                    res_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        op_count  <= op_count + CNT_W'(1);
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl: table of command/result vectors plus hand sequences for backpressure and reset.
module tb_alu_exec_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [1:0] cmd_dst;
    logic [1:0] cmd_src_a;
    logic [1:0] cmd_src_b;
    logic       cmd_imm_en;
    logic [3:0] cmd_imm;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_f;
    logic [3:0] alu_y;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_data;
    logic       res_zero;
    logic       busy;
    logic [7:0] op_count;

    int tests     = 0;
    int fails     = 0;
    int exp_count = 0;

    always #5 clk = ~clk;

    alu_exec_ctrl #(.DATA_W(4), .NUM_REGS(4), .ADDR_W(2), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_dst(cmd_dst), .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b),
        .cmd_imm_en(cmd_imm_en), .cmd_imm(cmd_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_y(alu_y),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_zero(res_zero), .busy(busy), .op_count(op_count)
    );

    // Behavioural model of the external combinational ALU.
    logic [3:0] bx;
    always_comb begin
        bx    = alu_f[2] ? ~alu_b : alu_b;
        alu_y = '0;
        case (alu_f[1:0])
            2'b00: alu_y = alu_a & bx;
            2'b01: alu_y = alu_a | bx;
            2'b10: alu_y = alu_a + bx + {3'b000, alu_f[2]};
            default: alu_y = alu_f[2] ? {3'b000, (alu_a > alu_b)} : {3'b000, (alu_a == alu_b)};
        endcase
    end

    typedef struct {
        logic [2:0] op;
        logic [1:0] dst;
        logic [1:0] sa;
        logic [1:0] sb;
        logic       ie;
        logic [3:0] imm;
        logic [3:0] exp_data;
        logic       exp_zero;
    } vec_t;

    vec_t vecs [18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives one command and walks it to RESP, checking handshake timing on the way.
    task automatic issue(input logic [2:0] op, input logic [1:0] dst, input logic [1:0] sa,
                         input logic [1:0] sb, input logic ie, input logic [3:0] imm);
        @(negedge clk);
        cmd_op = op; cmd_dst = dst; cmd_src_a = sa; cmd_src_b = sb;
        cmd_imm_en = ie; cmd_imm = imm; cmd_valid = 1'b1;
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("exec_res_valid", 32'(res_valid), 32'd0);
        check("exec_cmd_ready", 32'(cmd_ready), 32'd0);
        check("exec_alu_f", 32'(alu_f), 32'(op));
        @(posedge clk);
        @(negedge clk);
        check("resp_res_valid", 32'(res_valid), 32'd1);
    endtask

    task automatic complete(input logic [3:0] exp_data, input logic exp_zero);
        check("res_data", 32'(res_data), 32'(exp_data));
        check("res_zero", 32'(res_zero), 32'(exp_zero));
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        exp_count++;
        check("op_count", 32'(op_count), 32'(exp_count % 256));
        check("idle_res_valid", 32'(res_valid), 32'd0);
    endtask

    initial begin
        //           op      dst  sa   sb   ie    imm    data   zero
        vecs[0]  = '{3'b010, 2'd1, 2'd0, 2'd0, 1'b1, 4'd5,  4'd5,  1'b0}; // R1=5
        vecs[1]  = '{3'b010, 2'd2, 2'd0, 2'd0, 1'b1, 4'd3,  4'd3,  1'b0}; // R2=3
        vecs[2]  = '{3'b011, 2'd0, 2'd1, 2'd2, 1'b0, 4'd0,  4'd0,  1'b1}; // 5==3
        vecs[3]  = '{3'b111, 2'd0, 2'd1, 2'd2, 1'b0, 4'd0,  4'd1,  1'b0}; // 5>3
        vecs[4]  = '{3'b010, 2'd1, 2'd0, 2'd0, 1'b1, 4'd3,  4'd3,  1'b0}; // R1=3
        vecs[5]  = '{3'b010, 2'd2, 2'd0, 2'd0, 1'b1, 4'd5,  4'd5,  1'b0}; // R2=5
        vecs[6]  = '{3'b110, 2'd3, 2'd1, 2'd2, 1'b0, 4'd0,  4'hE,  1'b0}; // 3-5 wraps
        vecs[7]  = '{3'b010, 2'd3, 2'd3, 2'd0, 1'b1, 4'd2,  4'd0,  1'b1}; // E+2 -> 0
        vecs[8]  = '{3'b010, 2'd1, 2'd0, 2'd0, 1'b1, 4'd7,  4'd7,  1'b0}; // R1=7
        vecs[9]  = '{3'b010, 2'd2, 2'd0, 2'd0, 1'b1, 4'd7,  4'd7,  1'b0}; // R2=7
        vecs[10] = '{3'b011, 2'd0, 2'd1, 2'd2, 1'b0, 4'd0,  4'd1,  1'b0}; // 7==7
        vecs[11] = '{3'b000, 2'd3, 2'd1, 2'd0, 1'b1, 4'hC,  4'd4,  1'b0}; // 7&C
        vecs[12] = '{3'b001, 2'd3, 2'd3, 2'd0, 1'b1, 4'd1,  4'd5,  1'b0}; // 4|1
        vecs[13] = '{3'b100, 2'd0, 2'd1, 2'd0, 1'b1, 4'd2,  4'd5,  1'b0}; // 7&~2
        vecs[14] = '{3'b010, 2'd0, 2'd0, 2'd0, 1'b1, 4'd9,  4'd9,  1'b0}; // write to R0 dropped
        vecs[15] = '{3'b010, 2'd2, 2'd0, 2'd0, 1'b0, 4'd0,  4'd0,  1'b1}; // R0+R0, R2=0
        vecs[16] = '{3'b010, 2'd1, 2'd1, 2'd1, 1'b0, 4'd0,  4'hE,  1'b0}; // R1=R1+R1
        vecs[17] = '{3'b010, 2'd0, 2'd1, 2'd0, 1'b1, 4'd0,  4'hE,  1'b0}; // read back R1

        rst = 1'b1; cmd_valid = 1'b0; res_ready = 1'b0;
        cmd_op = '0; cmd_dst = '0; cmd_src_a = '0; cmd_src_b = '0; cmd_imm_en = 1'b0; cmd_imm = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_data", 32'(res_data), 32'd0);
        check("rst_res_zero", 32'(res_zero), 32'd1);
        check("rst_op_count", 32'(op_count), 32'd0);
        check("rst_alu_abf", {20'd0, alu_a, alu_b, 1'b0, alu_f}, 32'd0);

        for (int i = 0; i < 18; i++) begin
            issue(vecs[i].op, vecs[i].dst, vecs[i].sa, vecs[i].sb, vecs[i].ie, vecs[i].imm);
            complete(vecs[i].exp_data, vecs[i].exp_zero);
        end

        // R0 still reads zero after the dropped write; operands hold into RESP.
        issue(3'b010, 2'd0, 2'd0, 2'd0, 1'b1, 4'd1);
        check("r0_alu_a", 32'(alu_a), 32'd0);
        check("r0_alu_b", 32'(alu_b), 32'd1);
        complete(4'd1, 1'b0);

        // Backpressure: result held, junk command ignored.
        issue(3'b010, 2'd3, 2'd0, 2'd0, 1'b1, 4'd6);
        cmd_op = 3'b000; cmd_dst = 2'd1; cmd_imm = 4'hF; cmd_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_res_valid", 32'(res_valid), 32'd1);
            check("bp_res_data", 32'(res_data), 32'd6);
            check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            check("bp_busy", 32'(busy), 32'd1);
            check("bp_op_count", 32'(op_count), 32'(exp_count % 256));
        end
        cmd_valid = 1'b0;
        complete(4'd6, 1'b0);
        check("bp_after_ready", 32'(cmd_ready), 32'd1);
        // R1 must not have been overwritten by the ignored command.
        issue(3'b010, 2'd0, 2'd1, 2'd0, 1'b1, 4'd0);
        complete(4'hE, 1'b0);

        // Reset during EXEC: writeback to R2 abandoned, counters cleared.
        @(negedge clk);
        cmd_op = 3'b010; cmd_dst = 2'd2; cmd_src_a = 2'd0; cmd_imm_en = 1'b1; cmd_imm = 4'd6;
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_count = 0;
        check("mid_rst_res_valid", 32'(res_valid), 32'd0);
        check("mid_rst_op_count", 32'(op_count), 32'd0);
        check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("mid_rst_res_zero", 32'(res_zero), 32'd1);
        check("mid_rst_alu_a", 32'(alu_a), 32'd0);
        issue(3'b010, 2'd0, 2'd2, 2'd0, 1'b1, 4'd0);
        complete(4'd0, 1'b1);
        issue(3'b010, 2'd0, 2'd1, 2'd0, 1'b1, 4'd0);
        complete(4'd0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
